// File: rtl/regfile_pkg.sv
// regfile_pkg: shared write-op encoding for register_file.
// Holds the op_t typedef and the OP_* constants.
package regfile_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_INC  = 2'b01;
  localparam op_t OP_DEC  = 2'b10;
  localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/register_file_if.sv
// register_file_if: write port, two read ports and flags.
// master drives bus/we/waddr/op/raddr_*; slave drives out_*/zero/carry.
interface register_file_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  import regfile_pkg::*;

  localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] bus;
  logic             we;
  logic [AW-1:0]    waddr;
  op_t              op;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             zero;
  logic             carry;

  modport master (
    output bus, we, waddr, op,
    output raddr_a, raddr_b,
    input  out_a, out_b, zero, carry
  );

  modport slave (
    input  bus, we, waddr, op,
    input  raddr_a, raddr_b,
    output out_a, out_b, zero, carry
  );

endinterface

// File: rtl/regfile_next.sv
// regfile_next: next-value/carry for one write op (combinational).
// Ports: cur, bus, op in; nxt, cout out.
module regfile_next
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] bus,
  input  op_t              op,
  output logic [WIDTH-1:0] nxt,
  output logic             cout
);

  always_comb begin
    nxt  = '0;
    cout = 1'b0;
    unique case (op)
      OP_LOAD: nxt = bus;
      OP_INC:  {cout, nxt} = {1'b0, cur} + 1'b1;
      OP_DEC:  {cout, nxt} = {1'b0, cur} - 1'b1;
      OP_CLR:  nxt = '0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// register_file: NREGS x WIDTH bank, one write port, two async reads.
// Ports: clk, clr (async high), rf (slave). Option: REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic            clk,
  input logic            clr,
  register_file_if.slave rf
);

  localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             cout;
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             zero_q;
  logic             carry_q;

  function automatic logic in_rng(logic [AW-1:0] a);
    return {1'b0, a} < NREGS[AW:0];
  endfunction

  assign wr_ok = rf.we && in_rng(rf.waddr);
  assign cur   = in_rng(rf.waddr) ? regs[rf.waddr] : '0;

  regfile_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur  (cur),
    .bus  (rf.bus),
    .op   (rf.op),
    .nxt  (nxt),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (wr_ok) begin
      regs[rf.waddr] <= nxt;
      zero_q         <= (nxt == '0);
      carry_q        <= cout;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_rng(rf.raddr_a))
      rd_a = regs[rf.raddr_a];
    if (in_rng(rf.raddr_b))
      rd_b = regs[rf.raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && rf.raddr_a == rf.waddr)
      rd_a = nxt;
    if (wr_ok && rf.raddr_b == rf.waddr)
      rd_b = nxt;
`endif
  end

  assign rf.out_a = rd_a;
  assign rf.out_b = rd_b;
  assign rf.zero  = zero_q;
  assign rf.carry = carry_q;

endmodule

// File: doc/register_file.md
# register_file

Parametrised general-purpose register bank that generalises the team's single-purpose 8-bit load registers (A, B, OUT, IR, MAR) into one block. It holds NREGS registers of WIDTH bits, each written from the bus through one write port. Each write can load, increment, decrement or clear the addressed register. Two asynchronous read ports feed the ALU and the bus driver, and registered zero/carry flags describe the most recent write.

## Interface
- WIDTH, 8, data width of every register, ≥2
- NREGS, 4, number of registers, 2..16; AW = max(1, clog2(NREGS)) is a derived localparam
- clk  in  1  system clock, all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high; clears all registers and flags
- bus  in  WIDTH  write data for OP_LOAD
- we  in  1  write strobe; no state changes when low
- waddr  in  AW  destination register index
- op  in  2  write operation: 00 OP_LOAD, 01 OP_INC, 10 OP_DEC, 11 OP_CLR
- raddr_a  in  AW  read port A index
- raddr_b  in  AW  read port B index
- out_a  out  WIDTH  contents of register raddr_a
- out_b  out  WIDTH  contents of register raddr_b
- zero  out  1  registered: the result of the last accepted write was 0
- carry  out  1  registered: the last accepted write wrapped around

## Operation
- Accepted write: we=1 and waddr<NREGS at a rising clk edge.
- Next value of reg[waddr] for each op:
  - OP_LOAD: bus
  - OP_INC: reg+1, modulo 2^WIDTH
  - OP_DEC: reg-1, modulo 2^WIDTH
  - OP_CLR: 0
- Flag updates on an accepted write:
  - zero is set to (next value == 0).
  - carry is set to 1 only for OP_INC from all-ones, or OP_DEC from 0; otherwise 0. OP_LOAD and OP_CLR always clear carry.
- Flags and registers hold their values when no write is accepted.
- Out-of-range waddr (NREGS not a power of two): the write is ignored, with no register or flag change.
- Reads are combinational. A read with an out-of-range address returns 0.
- Both read ports may address the same register, or the write target, in the same cycle.
- Only the addressed register changes; all others hold.

## Timing
- Reset: while clr is high, every register, zero and carry are 0, so out_a = out_b = 0. Reset takes effect immediately, with no clock needed.
- Reset during an active write: the reset wins and the write is lost. The first write can be accepted at the first rising edge after clr falls.
- Write latency: the new value is visible on out_a/out_b one cycle after the accepting edge (bypass disabled).
- Flag latency: zero and carry are valid in the same cycle the new register value appears.
- Back-to-back writes to the same register chain correctly. Example: INC, INC from 5 gives 6, then 7, with one write per cycle and no stall.
- Read-during-write to the same address returns the old value that cycle (bypass disabled).

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1, the address is in range and raddr_x==waddr, out_x shows the next value (load, inc, dec or clear result) combinationally in the same cycle. Flags are unaffected and remain registered.
- Undefined: no forwarding; reads always show stored contents. This is the default.

## Structure
- Package regfile_pkg holds:
  - the op encoding constants OP_LOAD, OP_INC, OP_DEC, OP_CLR
  - a 2-bit op typedef
- AW is derived locally in register_file from NREGS.
- One sub-module, regfile_next, is combinational. It takes the current value, bus and op, and returns the next value and the carry-out. It is shared by the write path and by the bypass path when that is enabled.
- The register array is kept as a flat array inside register_file.

## Test plan
- Reset: assert clr mid-write with reg0=0x3C pending -> all out_* = 0x00, zero=0, carry=0 immediately; the write is lost.
- Load and read: LOAD 0xA5 to r1, LOAD 0x5A to r2; raddr_a=1, raddr_b=2 -> out_a=0xA5, out_b=0x5A one cycle later; zero=0.
- Wrap-around: LOAD 0xFF to r3, then INC r3 -> r3=0x00, zero=1, carry=1. Then DEC r3 -> 0xFF, zero=0, carry=1.
- Hold: DEC r0 from 0x02 twice -> 0x01 then 0x00 with zero=1. Then drive we=0 for 3 cycles with changing op and bus -> r0 and flags unchanged.
- Read-during-write: LOAD 0x77 to r2 while raddr_a=2 and r2=0x10 -> out_a=0x10 that cycle without the macro, 0x77 with REGFILE_BYPASS_EN. Both builds give 0x77 next cycle.
- Out of range (NREGS=3): write to waddr=3 -> no register or flag change; raddr_b=3 -> out_b=0.
